module_decodi: RTL and testbench

- SECDED decoder for an extended Hamming(8,4) codeword: 7-bit Hamming(7,4) plus one global even-parity bit.
- Computes the 3-bit syndrome and the global parity check, corrects any single-bit error, flags double errors, and extracts the 4 data bits.
- Sits at the receive side, after the channel/error-injection stage and before the display/consumer logic.
- Output is registered, with one cycle of latency.

---
 rtl/hamming_pkg.sv | 35 +++
 rtl/hamming_syndrome.sv | 24 ++
 rtl/module_decodi.sv | 67 ++++++
 tb/tb_module_decodi.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the extended Hamming(8,4) codec.
// Bit positions follow the classic 1..7 numbering mapped onto bits 0..6.
package hamming_pkg;

    localparam int CODE_W = 8;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D1 = 2;
    localparam int P4 = 3;
    localparam int D2 = 4;
    localparam int D3 = 5;
    localparam int D4 = 6;
    localparam int P0 = 7;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SYN_W-1:0]  syn;
        logic              err_single;
        logic              err_double;
    } dec_t;

    function automatic logic [SYN_W-1:0] calc_syndrome(
        input logic [CODE_W-1:0] c
    );
        logic [SYN_W-1:0] s;
        s[0] = c[P1] ^ c[D1] ^ c[D2] ^ c[D4];
        s[1] = c[P2] ^ c[D1] ^ c[D3] ^ c[D4];
        s[2] = c[P4] ^ c[D2] ^ c[D3] ^ c[D4];
        return s;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome, global parity and single-bit correction.
// The corrected word assumes a single error; the caller decides whether to use it.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] datos_cod,
    output logic [SYN_W-1:0]  sindrome,
    output logic              paridad,
    output logic [CODE_W-1:0] corregido
);

    always_comb begin
        sindrome  = calc_syndrome(datos_cod);
        paridad   = ^datos_cod;
        corregido = datos_cod;
        // Syndrome value k points at Hamming position k, i.e. bit k-1
        for (int i = 0; i < CODE_W - 1; i++) begin
            if (sindrome == SYN_W'(i + 1)) begin
                corregido[i] = ~datos_cod[i];
            end
        end
    end

endmodule

// File: rtl/module_decodi.sv
// SECDED receive-side decoder: classify, correct, extract, register.
// One cycle of latency; registers update every cycle, qualified by valid_out.
module module_decodi
    import hamming_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] datos_cod,
    input  logic              valid_in,
    output logic [DATA_W-1:0] datos_out,
    output logic              valid_out,
    output logic [SYN_W-1:0]  sindrome,
    output logic              err_single,
    output logic              err_double
);

    logic [SYN_W-1:0]  syn;
    logic              par;
    logic [CODE_W-1:0] corr;
    logic [CODE_W-1:0] word;
    logic              unused_bits;
    dec_t              dec;

    hamming_syndrome u_syn (
        .datos_cod (datos_cod),
        .sindrome  (syn),
        .paridad   (par),
        .corregido (corr)
    );

    always_comb begin
        dec     = '0;
        dec.syn = syn;
        word    = datos_cod;
        unique case ({|syn, par})
            2'b00: ;
            2'b11: begin
                dec.err_single = 1'b1;
                word           = corr;
            end
            // Only p0 flipped: data bits are already intact
            2'b01: dec.err_single = 1'b1;
            2'b10: dec.err_double = 1'b1;
            default: ;
        endcase
        dec.data = {word[D4], word[D3], word[D2], word[D1]};
    end

    assign unused_bits = ^{word[P0], word[P4], word[P2], word[P1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            datos_out  <= '0;
            valid_out  <= 1'b0;
            sindrome   <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
        end else begin
            datos_out  <= dec.data;
            valid_out  <= valid_in;
            sindrome   <= dec.syn;
            err_single <= dec.err_single;
            err_double <= dec.err_double;
        end
    end

endmodule

// File: tb/tb_module_decodi.sv
// Self-checking bench for module_decodi: vector table, hand sequences,
// and random encode/corrupt traffic against a position-arithmetic model.
module tb_module_decodi;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] datos_cod;
    logic       valid_in;
    logic [3:0] datos_out;
    logic       valid_out;
    logic [2:0] sindrome;
    logic       err_single;
    logic       err_double;

    int n_checks = 0;
    int n_fail   = 0;

    module_decodi dut (
        .clk        (clk),
        .rst        (rst),
        .datos_cod  (datos_cod),
        .valid_in   (valid_in),
        .datos_out  (datos_out),
        .valid_out  (valid_out),
        .sindrome   (sindrome),
        .err_single (err_single),
        .err_double (err_double)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic [9:0] exp;
    } vec_t;

    function automatic logic [9:0] outs();
        return {valid_out, datos_out, sindrome, err_single, err_double};
    endfunction

    task automatic check(input string name, input logic [9:0] act,
                         input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // XOR of the Hamming positions of all set bits among bits 0..6
    function automatic logic [2:0] pos_xor(input logic [7:0] w);
        logic [2:0] s = 3'd0;
        for (int i = 0; i < 7; i++)
            if (w[i]) s = s ^ 3'(i + 1);
        return s;
    endfunction

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] w = 8'd0;
        logic [2:0] s;
        w[2] = d[0];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        s    = pos_xor(w);
        w[0] = s[0];
        w[1] = s[1];
        w[3] = s[2];
        w[7] = ^w[6:0];
        return w;
    endfunction

    function automatic logic [3:0] raw(input logic [7:0] w);
        return {w[6], w[5], w[4], w[2]};
    endfunction

    vec_t vecs[7];

    initial begin
        logic [9:0] exp_prev;
        logic       have_prev;

        vecs[0] = '{8'b0000_0000, 10'b1_0000_000_0_0};
        vecs[1] = '{8'b0101_0101, 10'b1_1011_000_0_0};
        vecs[2] = '{8'b0100_0101, 10'b1_1011_101_1_0};
        vecs[3] = '{8'b1101_0101, 10'b1_1011_000_1_0};
        vecs[4] = '{8'b0000_1111, 10'b1_0001_100_0_1};
        vecs[5] = '{8'b1011_0010, 10'b1_0110_001_0_1};
        vecs[6] = '{8'b0001_0101, 10'b1_1011_111_1_0};

        rst       = 1'b1;
        datos_cod = 8'hFF;
        valid_in  = 1'b1;
        #1;
        check("reset_async", outs(), 10'd0);
        repeat (2) @(negedge clk);
        check("reset_held", outs(), 10'd0);
        rst = 1'b0;

        // Table: drive on negedge, expect result one negedge later
        for (int i = 0; i < 7; i++) begin
            datos_cod = vecs[i].code;
            valid_in  = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Latency: new input must not appear before the next edge
        datos_cod = 8'b0000_1111;
        valid_in  = 1'b0;
        @(posedge clk);
        #1;
        check("lat_edge", outs(), 10'b0_0001_100_0_1);
        datos_cod = 8'b0101_0101;
        valid_in  = 1'b1;
        #2;
        check("lat_hold", outs(), 10'b0_0001_100_0_1);
        @(posedge clk);
        #1;
        check("lat_next", outs(), 10'b1_1011_000_0_0);

        // Random back-to-back traffic with 0, 1 or 2 flipped bits
        have_prev = 1'b0;
        exp_prev  = '0;
        @(negedge clk);
        for (int n = 0; n < 300; n++) begin
            logic [3:0] d;
            logic [7:0] w;
            logic [2:0] s;
            int         nf, a, b;
            logic       v;
            if (have_prev) check("random", outs(), exp_prev);
            d  = 4'($urandom);
            v  = 1'($urandom);
            nf = $urandom_range(0, 2);
            w  = encode(d);
            s  = 3'd0;
            a  = $urandom_range(0, 7);
            b  = (a + $urandom_range(1, 7)) % 8;
            if (nf >= 1) begin
                w[a] = ~w[a];
                if (a < 7) s = s ^ 3'(a + 1);
            end
            if (nf == 2) begin
                w[b] = ~w[b];
                if (b < 7) s = s ^ 3'(b + 1);
            end
            datos_cod = w;
            valid_in  = v;
            exp_prev  = {v, (nf == 2) ? raw(w) : d, s, nf == 1, nf == 2};
            have_prev = 1'b1;
            @(negedge clk);
        end
        check("random_last", outs(), exp_prev);

        // Mid-stream reset clears outputs without a clock edge
        datos_cod = 8'b0100_0101;
        valid_in  = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid", outs(), 10'd0);
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        check("post_rst_idle", outs(), 10'b0_1011_101_1_0);
        datos_cod = 8'b1011_0010;
        valid_in  = 1'b1;
        @(negedge clk);
        check("post_rst_first", outs(), 10'b1_0110_001_0_1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
